jt03_dac_rx: RTL and testbench
==============================

// Module: jt03_dac_rx
// PURPOSE
// - Receiving end of the mono YM2203 sound path: deserialises the YM3014-style
//   floating-point serial stream produced from the 16-bit accumulated sample.
// - Rebuilds a signed 16-bit linear sample and tracks frame alignment.
// - Sits between the FM core's serial DAC port and the board-level mixer or
//   audio filter.
// PARAMETERS
// - LOCK_FRAMES  2   consecutive good frames required before the block leaves HUNT
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   asynchronous, active-low reset
// - clk_en     in   1   bit enable; all sequential updates are gated by it
// - sd         in   1   serial data, one bit per clk_en cycle, MSB first
// - load       in   1   high on the clk_en cycle that carries the last bit of a frame
// - snd        out  16  signed linear sample
// - snd_valid  out  1   single clk-cycle pulse when snd updates
// - locked     out  1   high while in LOCK
// - frame_err  out  1   single clk-cycle pulse on a misaligned load
// BEHAVIOUR
// - Reset: snd=0, snd_valid=0, locked=0, frame_err=0.
//   Reset also clears the shift register and sets the bit counter to 0, the
//   good-frame counter to 0 and the state to HUNT.
// - Frame: 16 bits, MSB first.
//   - f[15:13]: padding, ignored.
//   - f[12:3]: mantissa m[9:0], offset binary.
//   - f[2:0]: exponent e.
// - Shifting: each clk_en cycle, sr <= {sr[14:0], sd} and the bit counter
//   increments, saturating at 31.
// - Frame check on a clk_en cycle with load=1, using the word that includes the
//   current sd bit.
//   - Good frame: the counter including this bit equals 16.
//   - In all cases the counter resets to 0 after the check.
// - Conversion: s = {~m[9], m[8:0]}, a signed 10-bit value.
//   - e>=1: snd = sext16(s) <<< (e-1).
//   - e=0: snd = sext16(s) >>> 1.
//   - e=7 gives the full 16-bit range; the result never overflows.
// - FSM:
//   - HUNT, good frame: the good-frame counter increments. On reaching
//     LOCK_FRAMES, go to LOCK and output this frame.
//   - HUNT, bad frame: frame_err pulses and the good-frame counter clears.
//   - LOCK, good frame: snd updates and snd_valid pulses.
//   - LOCK, bad frame: frame_err pulses, go to HUNT, good-frame counter clears,
//     snd holds its last value.
// - Latency: snd, snd_valid and frame_err are registered and update on the clk
//   edge that samples the load cycle. The pulses drop on the following clk
//   edge, whatever clk_en is doing.
// - Outside LOCK, snd never updates.
// - clk_en low: no state changes; load and sd are ignored.
// - load held for multiple clk_en cycles: each cycle is checked as a separate
//   frame end. The second check sees count 1 and is therefore a bad frame.
// - Reset asserted mid-frame: everything returns to reset values immediately,
//   and the partial frame is discarded.
// TESTING
// - Reset behaviour: assert rst_n=0 mid-frame -> all outputs 0, locked=0.
//   After release, 16 bits + load -> no snd_valid, because the block is still
//   in HUNT.
// - Lock-up: two good frames, the second with m=10'h3FF, e=7 ->
//   locked=1, snd=16'h7FC0, one snd_valid pulse.
// - Negative/low exponent: m=10'h000, e=0 -> snd=16'hFF00.
//   m=10'h200, e=1 -> snd=0.
// - Misalignment: once locked, load after 15 bits -> frame_err pulse,
//   locked=0, snd unchanged.
//   Then two good frames -> locked=1 again.
// - clk_en gating: clk_en toggling 1-in-4 during a frame -> the same snd as
//   with clk_en tied high. sd/load changes while clk_en=0 have no effect.
// - Saturation: 40 bits with no load, then load -> frame_err, counter restarts,
//   and the next 16-bit frame counts as good.

Source files
------------

// File: rtl/jt03_dac_rx.sv
// jt03_dac_rx: receiver for the YM3014-style floating-point serial DAC stream.
// Deserialises 16-bit MSB-first frames, rebuilds a signed 16-bit linear
// sample from the 10-bit mantissa / 3-bit exponent pair and tracks frame
// alignment with a HUNT/LOCK state machine.
module jt03_dac_rx #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        sd,
  input  logic        load,
  output logic [15:0] snd,
  output logic        snd_valid,
  output logic        locked,
  output logic        frame_err
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    sr;
  logic [4:0]     bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]  good_cnt, good_nxt;

  logic [15:0]        word;
  logic [4:0]         cnt_inc;
  logic [9:0]         mant;
  logic [2:0]         expo;
  logic signed [9:0]  s10;
  logic signed [15:0] s16;
  logic signed [15:0] conv;
  logic               good_frame;
  logic               upd;
  logic               err;

  // Padding bits f[15:13] travel through the shift register but carry no data.
  logic unused_pad;
  assign unused_pad = ^word[15:13];

  assign locked = (state == LOCK);

  // Frame assembly and float-to-linear conversion of the word ending in sd.
  always_comb begin
    word    = {sr[14:0], sd};
    cnt_inc = (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;
    mant    = word[12:3];
    expo    = word[2:0];
    s10     = {~mant[9], mant[8:0]};
    s16     = {{6{s10[9]}}, s10};
    if (expo == 3'd0) conv = s16 >>> 1;
    else              conv = s16 <<< (expo - 3'd1);
    good_frame = (cnt_inc == 5'd16);
  end

  // Next-state logic: frame checks only happen on enabled load cycles.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_nxt   = state;
    good_nxt    = good_cnt;
    bit_cnt_nxt = bit_cnt;
    upd         = 1'b0;
    err         = 1'b0;
    if (clk_en) begin
      bit_cnt_nxt = load ? 5'd0 : cnt_inc;
      if (load) begin
        case (state)
          HUNT: begin
            if (good_frame) begin
              if (good_cnt + GW'(1) >= GW'(LOCK_FRAMES)) begin
                state_nxt = LOCK;
                good_nxt  = '0;
                upd       = 1'b1;
              end else begin
                good_nxt = good_cnt + GW'(1);
              end
            end else begin
              err      = 1'b1;
              good_nxt = '0;
            end
          end
          LOCK: begin
            if (good_frame) begin
              upd = 1'b1;
            end else begin
              err       = 1'b1;
              state_nxt = HUNT;
              good_nxt  = '0;
            end
          end
          default: state_nxt = HUNT;
        endcase
      end
    end
  end

  // State, shift register and registered outputs; pulses self-clear each clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      good_cnt  <= '0;
      snd       <= '0;
      snd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      bit_cnt   <= bit_cnt_nxt;
      snd_valid <= upd;
      frame_err <= err;
      if (clk_en) sr <= word;
      if (upd) snd <= conv;
    end
  end

endmodule

// File: tb/tb_jt03_dac_rx.sv
// tb_jt03_dac_rx: directed, table-driven bench for the serial DAC receiver.
module tb_jt03_dac_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        sd;
  logic        load;
  logic [15:0] snd;
  logic        snd_valid;
  logic        locked;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  typedef struct {
    logic [9:0]  m;
    logic [2:0]  e;
    logic [15:0] snd;
  } vec_t;

  vec_t vecs[10];

  jt03_dac_rx #(.LOCK_FRAMES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .sd       (sd),
    .load     (load),
    .snd      (snd),
    .snd_valid(snd_valid),
    .locked   (locked),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk cycle with the given inputs; outputs are stable 1 time unit later.
  task automatic tick(input logic en, input logic d, input logic ld);
    clk_en = en;
    sd     = d;
    load   = ld;
    @(posedge clk);
    #1;
    if (snd_valid) n_valid++;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n, input logic ld_last);
    for (int i = n - 1; i >= 0; i--) tick(1'b1, bits[i], ld_last && (i == 0));
  endtask

  function automatic logic [15:0] frame(input logic [9:0] m, input logic [2:0] e);
    return {3'b101, m, e};
  endfunction

  task automatic send_frame(input logic [9:0] m, input logic [2:0] e);
    send_bits({48'h0, frame(m, e)}, 16, 1'b1);
  endtask

  logic [15:0] exp_snd;
  logic [15:0] w;
  logic [31:0] r;
  int          v0;

  initial begin
    vecs[0] = '{10'h000, 3'd0, 16'hFF00};
    vecs[1] = '{10'h200, 3'd1, 16'h0000};
    vecs[2] = '{10'h000, 3'd7, 16'h8000};
    vecs[3] = '{10'h201, 3'd2, 16'h0002};
    vecs[4] = '{10'h1FF, 3'd1, 16'hFFFF};
    vecs[5] = '{10'h1FF, 3'd0, 16'hFFFF};
    vecs[6] = '{10'h280, 3'd4, 16'h0400};
    vecs[7] = '{10'h300, 3'd5, 16'h1000};
    vecs[8] = '{10'h100, 3'd6, 16'hE000};
    vecs[9] = '{10'h3FF, 3'd0, 16'h00FF};

    rst_n = 1'b0; clk_en = 1'b0; sd = 1'b0; load = 1'b0;
    #23;
    check("reset_snd", snd, 16'h0);
    check("reset_valid", {15'h0, snd_valid}, 16'h0);
    check("reset_locked", {15'h0, locked}, 16'h0);
    check("reset_ferr", {15'h0, frame_err}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock-up: first good frame stays in HUNT, second locks and outputs.
    send_frame(10'h155, 3'd3);
    check("hunt1_valid", {15'h0, snd_valid}, 16'h0);
    check("hunt1_locked", {15'h0, locked}, 16'h0);
    check("hunt1_ferr", {15'h0, frame_err}, 16'h0);
    send_frame(10'h3FF, 3'd7);
    exp_snd = 16'h7FC0;
    check("lock_valid", {15'h0, snd_valid}, 16'h1);
    check("lock_locked", {15'h0, locked}, 16'h1);
    check("lock_snd", snd, exp_snd);
    tick(1'b0, 1'b1, 1'b1);
    check("pulse_drop_valid", {15'h0, snd_valid}, 16'h0);
    check("pulse_drop_snd", snd, exp_snd);

    // Conversion table, applied while locked.
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].m, vecs[i].e);
      exp_snd = vecs[i].snd;
      check($sformatf("vec%0d_valid", i), {15'h0, snd_valid}, 16'h1);
      check($sformatf("vec%0d_snd", i), snd, exp_snd);
      check($sformatf("vec%0d_ferr", i), {15'h0, frame_err}, 16'h0);
    end

    // Misalignment: load after 15 bits drops lock and keeps snd.
    send_bits({48'h0, frame(10'h000, 3'd7)}, 15, 1'b1);
    check("misal_ferr", {15'h0, frame_err}, 16'h1);
    check("misal_locked", {15'h0, locked}, 16'h0);
    check("misal_valid", {15'h0, snd_valid}, 16'h0);
    check("misal_snd", snd, exp_snd);
    tick(1'b0, 1'b0, 1'b0);
    check("misal_ferr_drop", {15'h0, frame_err}, 16'h0);
    send_frame(10'h200, 3'd1);
    check("relock1_locked", {15'h0, locked}, 16'h0);
    check("relock1_snd", snd, exp_snd);
    send_frame(10'h3FF, 3'd7);
    exp_snd = 16'h7FC0;
    check("relock2_locked", {15'h0, locked}, 16'h1);
    check("relock2_snd", snd, exp_snd);

    // clk_en 1-in-4 with garbage on sd/load during disabled cycles.
    w  = frame(10'h155, 3'd5);
    v0 = n_valid;
    for (int i = 15; i >= 0; i--) begin
      repeat (3) begin
        r = $urandom;
        tick(1'b0, r[0], r[1]);
      end
      tick(1'b1, w[i], i == 0);
    end
    exp_snd = 16'hF550;
    check("gated_snd", snd, exp_snd);
    check("gated_valid", {15'h0, snd_valid}, 16'h1);
    check("gated_ferr", {15'h0, frame_err}, 16'h0);
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    check("gated_pulse_count", 16'(n_valid - v0), 16'd1);

    // load held for two enabled cycles: second check sees count 1.
    send_frame(10'h201, 3'd2);
    exp_snd = 16'h0002;
    check("held1_snd", snd, exp_snd);
    check("held1_ferr", {15'h0, frame_err}, 16'h0);
    tick(1'b1, 1'b0, 1'b1);
    check("held2_ferr", {15'h0, frame_err}, 16'h1);
    check("held2_locked", {15'h0, locked}, 16'h0);
    check("held2_snd", snd, exp_snd);

    // Saturation: 40 bits without load, then load.
    send_bits(64'h0, 40, 1'b0);
    check("sat_noerr", {15'h0, frame_err}, 16'h0);
    tick(1'b1, 1'b0, 1'b1);
    check("sat_ferr", {15'h0, frame_err}, 16'h1);
    send_frame(10'h100, 3'd6);
    check("sat_next_ferr", {15'h0, frame_err}, 16'h0);
    check("sat_next_locked", {15'h0, locked}, 16'h0);
    send_frame(10'h000, 3'd7);
    exp_snd = 16'h8000;
    check("sat_relock_locked", {15'h0, locked}, 16'h1);
    check("sat_relock_snd", snd, exp_snd);

    // Reset mid-frame: outputs clear immediately, partial frame discarded.
    send_bits(64'hAB, 8, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_snd", snd, 16'h0);
    check("mid_rst_locked", {15'h0, locked}, 16'h0);
    check("mid_rst_valid", {15'h0, snd_valid}, 16'h0);
    check("mid_rst_ferr", {15'h0, frame_err}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(10'h3FF, 3'd7);
    check("post_rst_valid", {15'h0, snd_valid}, 16'h0);
    check("post_rst_ferr", {15'h0, frame_err}, 16'h0);
    check("post_rst_locked", {15'h0, locked}, 16'h0);
    send_frame(10'h1FF, 3'd1);
    check("post_rst_lock", {15'h0, locked}, 16'h1);
    check("post_rst_snd", snd, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
